// File: rtl/instruction_fetch_unit.sv
// LEGv8 multi-cycle front end: owns the PC, fetches over a ready-based
// memory port and holds the instruction until the controller retires it.
module instruction_fetch_unit #(
    parameter logic [63:0] RESET_PC = 64'h0,
    parameter int          MAX_WAIT = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [63:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instruction,
    output logic [9:0]  opcode,
    output logic        instr_valid,
    input  logic        instr_done,
    input  logic        branch,
    input  logic        alu_zero,
    input  logic [63:0] branch_offset,
    output logic [63:0] pc,
    output logic [31:0] retired_count,
    output logic        fetch_err
);

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        ISSUE = 2'd1,
        ERR   = 2'd2
    } state_t;

    localparam logic [7:0] WAIT_LIMIT = 8'(MAX_WAIT);

    state_t      state;
    logic [7:0]  wait_cnt;
    logic [63:0] next_pc;
    logic        take_branch;

    // Branch target vs. sequential successor, picked at retirement
    always_comb begin
        take_branch = branch & alu_zero;
        next_pc     = pc + 64'd4;
        if (take_branch) begin
            next_pc = pc + (branch_offset << 2);
        end
    end

    // The address bus always reflects the current PC
    assign imem_addr = pc;
    assign opcode    = instruction[31:22];

    // Fetch/issue/error sequencing with all outputs registered
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= FETCH;
            pc            <= RESET_PC;
            instruction   <= 32'h0;
            instr_valid   <= 1'b0;
            imem_req      <= 1'b0;
            retired_count <= 32'h0;
            fetch_err     <= 1'b0;
            wait_cnt      <= 8'h0;
        end else begin
            unique case (state)
                FETCH: begin
                    if (!imem_req) begin
                        // first cycle out of reset: open the request
                        imem_req <= 1'b1;
                        wait_cnt <= 8'h0;
                    end else if (imem_ready) begin
                        instruction <= imem_rdata;
                        instr_valid <= 1'b1;
                        imem_req    <= 1'b0;
                        wait_cnt    <= 8'h0;
                        state       <= ISSUE;
                    end else if (wait_cnt + 8'd1 >= WAIT_LIMIT) begin
                        imem_req  <= 1'b0;
                        fetch_err <= 1'b1;
                        wait_cnt  <= wait_cnt + 8'd1;
                        state     <= ERR;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end
                ISSUE: begin
                    if (instr_done) begin
                        pc            <= next_pc;
                        retired_count <= retired_count + 32'd1;
                        instr_valid   <= 1'b0;
                        imem_req      <= 1'b1;
                        wait_cnt      <= 8'h0;
                        state         <= FETCH;
                    end
                end
                ERR: begin
                    imem_req    <= 1'b0;
                    instr_valid <= 1'b0;
                    fetch_err   <= 1'b1;
                end
                default: begin
                    state <= FETCH;
                end
            endcase
        end
    end

endmodule
